// File: rtl/custom_result_buffer.sv
// custom_result_buffer: tracks one in-flight op on the custom-logic PR block,
// captures its result after the loaded module's latency and holds up to two
// results in order until the CDB grants them. Branch misses squash speculative
// work, and branch successes clear the speculation flag.
// Optional build macro: CUSTOM_ZERO_LAT_EN (latency 0 pushes at the issue edge).
//
// state | meaning
// IDLE  | no op executing; an issue is accepted unless the queue is full
// EXEC  | op in flight; counter counts down to the result sample edge

`ifndef RRF_SEL
`define RRF_SEL 6
`endif
`ifndef SPECTAG_LEN
`define SPECTAG_LEN 5
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module custom_result_buffer (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue,
    input  logic [`RRF_SEL-1:0]     rrftag,
    input  logic                    dstval,
    input  logic [`SPECTAG_LEN-1:0] spectag,
    input  logic                    specbit,
    input  logic [3:0]              latency,
    input  logic [`DATA_LEN-1:0]    pr_result,
    input  logic                    prmiss,
    input  logic                    prsuccess,
    input  logic [`SPECTAG_LEN-1:0] prtag,
    input  logic [`SPECTAG_LEN-1:0] specfixtag,
    output logic                    busy,
    output logic                    cdb_req,
    input  logic                    cdb_grant,
    output logic [`RRF_SEL-1:0]     cdb_rrftag,
    output logic                    cdb_dstval,
    output logic [`DATA_LEN-1:0]    cdb_result
);

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    typedef struct packed {
        logic [`RRF_SEL-1:0]     rrftag;
        logic                    dstval;
        logic                    specbit;
        logic [`SPECTAG_LEN-1:0] spectag;
        logic [`DATA_LEN-1:0]    result;
    } entry_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [`RRF_SEL-1:0]     ex_rrftag_q, ex_rrftag_d;
    logic                    ex_dstval_q, ex_dstval_d;
    logic                    ex_specbit_q, ex_specbit_d;
    logic [`SPECTAG_LEN-1:0] ex_spectag_q, ex_spectag_d;
    entry_t                  q0_q, q0_d, q1_q, q1_d;
    logic [1:0]              count_q, count_d;

    logic   succ, accept, iss_kill, iss_sb, ex_kill, ex_sb, zero_lat;
    logic   v0, v1, pop, alive0, alive1, push_v;
    entry_t e0, e1, push_e;

    function automatic logic kill_f(input logic miss, input logic sb,
                                    input logic [`SPECTAG_LEN-1:0] tag,
                                    input logic [`SPECTAG_LEN-1:0] fix);
        return miss & sb & (|(tag & fix));
    endfunction

    // Speculation bookkeeping and queue slot liveness for this cycle
    always_comb begin
        succ     = prsuccess & ~prmiss;
        busy     = (state_q == EXEC) | (count_q == 2'd2);
        accept   = issue & ~busy;
        iss_kill = kill_f(prmiss, specbit, spectag, specfixtag);
        iss_sb   = specbit & ~(succ & (spectag == prtag));
        ex_kill  = kill_f(prmiss, ex_specbit_q, ex_spectag_q, specfixtag);
        ex_sb    = ex_specbit_q & ~(succ & (ex_spectag_q == prtag));
        v0       = (count_q != 2'd0);
        v1       = (count_q == 2'd2);
        pop      = v0 & cdb_grant;
        // a killed head is dropped anyway; the grant never reaches the tail
        alive0   = v0 & ~pop & ~kill_f(prmiss, q0_q.specbit, q0_q.spectag, specfixtag);
        alive1   = v1 & ~kill_f(prmiss, q1_q.specbit, q1_q.spectag, specfixtag);
        e0       = q0_q;
        e0.specbit = q0_q.specbit & ~(succ & (q0_q.spectag == prtag));
        e1       = q1_q;
        e1.specbit = q1_q.specbit & ~(succ & (q1_q.spectag == prtag));
`ifdef CUSTOM_ZERO_LAT_EN
        zero_lat = (latency == 4'd0);
`else
        zero_lat = 1'b0;
`endif
    end

    // Next-state logic: issue acceptance, countdown and result push
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ex_rrftag_d  = ex_rrftag_q;
        ex_dstval_d  = ex_dstval_q;
        ex_specbit_d = ex_specbit_q;
        ex_spectag_d = ex_spectag_q;
        push_v       = 1'b0;
        push_e       = '{rrftag: rrftag, dstval: dstval, specbit: iss_sb,
                         spectag: spectag, result: pr_result};
        case (state_q)
            IDLE: begin
                if (accept && !iss_kill) begin
                    if (zero_lat) begin
                        push_v = 1'b1;
                    end else begin
                        state_d      = EXEC;
                        cnt_d        = (latency == 4'd0) ? 4'd0 : latency - 4'd1;
                        ex_rrftag_d  = rrftag;
                        ex_dstval_d  = dstval;
                        ex_specbit_d = iss_sb;
                        ex_spectag_d = spectag;
                    end
                end
            end
            EXEC: begin
                ex_specbit_d = ex_sb;
                if (ex_kill) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    push_v  = 1'b1;
                    push_e  = '{rrftag: ex_rrftag_q, dstval: ex_dstval_q, specbit: ex_sb,
                                spectag: ex_spectag_q, result: pr_result};
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue compaction: survivors move toward the head, the push lands behind them
    always_comb begin
        q0_d    = '0;
        q1_d    = '0;
        count_d = 2'd0;
        if (alive0) begin
            q0_d = e0;
            if (alive1) begin
                q1_d    = e1;
                count_d = 2'd2;
            end else if (push_v) begin
                q1_d    = push_e;
                count_d = 2'd2;
            end else begin
                count_d = 2'd1;
            end
        end else if (alive1) begin
            q0_d = e1;
            if (push_v) begin
                q1_d    = push_e;
                count_d = 2'd2;
            end else begin
                count_d = 2'd1;
            end
        end else if (push_v) begin
            q0_d    = push_e;
            count_d = 2'd1;
        end
    end

    // State, counter, latched op fields and queue registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            ex_rrftag_q  <= '0;
            ex_dstval_q  <= 1'b0;
            ex_specbit_q <= 1'b0;
            ex_spectag_q <= '0;
            q0_q         <= '0;
            q1_q         <= '0;
            count_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ex_rrftag_q  <= ex_rrftag_d;
            ex_dstval_q  <= ex_dstval_d;
            ex_specbit_q <= ex_specbit_d;
            ex_spectag_q <= ex_spectag_d;
            q0_q         <= q0_d;
            q1_q         <= q1_d;
            count_q      <= count_d;
        end
    end

    // Head of the queue drives the CDB request directly
    always_comb begin
        cdb_req    = v0;
        cdb_rrftag = q0_q.rrftag;
        cdb_dstval = q0_q.dstval;
        cdb_result = q0_q.result;
    end

endmodule

// File: doc/custom_result_buffer.md
CUSTOM_RESULT_BUFFER -- requirements
Module: custom_result_buffer

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide port: issue  input  1  custom op issued to the custom-logic PR block this cycle.
REQ-004 SHALL provide port: rrftag  input  `RRF_SEL  destination rename tag of the issued op.
REQ-005 SHALL provide port: dstval  input  1  issued op writes a destination register.
REQ-006 SHALL provide ports: spectag  input  `SPECTAG_LEN, and specbit  input  1; speculation tag and flag of the issued op.
REQ-007 SHALL provide port: latency  input  4  cycle latency of the currently loaded PR module.
REQ-008 SHALL provide port: pr_result  input  `DATA_LEN  result output of the custom-logic PR block.
REQ-009 SHALL provide ports: prmiss  input  1; prsuccess  input  1; prtag  input  `SPECTAG_LEN; specfixtag  input  `SPECTAG_LEN; branch resolution.
REQ-010 SHALL provide port: busy  output  1  issue not accepted this cycle.
REQ-011 SHALL provide ports: cdb_req  output  1; cdb_grant  input  1; cdb_rrftag  output  `RRF_SEL; cdb_dstval  output  1; cdb_result  output  `DATA_LEN.

Function
REQ-012 SHALL implement FSM states IDLE and EXEC plus a 2-entry in-order output queue {rrftag, dstval, specbit, spectag, result}.
REQ-013 busy SHALL equal (state==EXEC) OR (queue count==2); issue while busy SHALL be ignored.
REQ-014 Accepted issue SHALL latch rrftag/dstval/spectag/specbit, load counter = max(latency,1)-1, go IDLE->EXEC.
REQ-015 In EXEC, counter SHALL decrement per cycle; at the edge where counter==0, pr_result and latched fields SHALL be pushed to the queue and state SHALL return to IDLE (result sampled L edges after issue edge).
REQ-016 cdb_req SHALL equal queue non-empty; cdb_* outputs SHALL present the head entry combinationally.
REQ-017 cdb_req AND cdb_grant SHALL pop the head at the edge; simultaneous push and pop SHALL be supported, count unchanged.
REQ-018 On prmiss, every valid entry (EXEC op, queue entries, and an issue in the same cycle) with specbit=1 and (spectag & specfixtag)!=0 SHALL be discarded; killed EXEC returns to IDLE; surviving tail SHALL compact to head.
REQ-019 Kill SHALL take precedence over grant, push, and issue of the same entry in the same cycle.
REQ-020 On prsuccess, every held entry with spectag==prtag SHALL clear its specbit; an issue in the same cycle with spectag==prtag SHALL be latched with specbit=0.
REQ-021 prmiss and prsuccess asserted together SHALL be treated as prmiss only.

Reset
REQ-022 While reset is low: state=IDLE, counter=0, queue count=0, all entry fields 0; busy=0, cdb_req=0, cdb_rrftag=0, cdb_dstval=0, cdb_result=0.
REQ-023 Reset asserted mid-EXEC or with queued entries SHALL discard all in-flight results without broadcast.

Configuration
REQ-024 Macro CUSTOM_ZERO_LAT_EN: when defined, latency==0 SHALL push pr_result directly into the queue at the issue edge, state remaining IDLE, busy = (count==2).
REQ-025 When CUSTOM_ZERO_LAT_EN is undefined, latency==0 SHALL behave as latency==1.

Verification
REQ-026 latency=3, issue rrftag=5 at edge 0, grant held 1 -> cdb_req rises after edge 3, cdb_rrftag=5, popped at edge 4.
REQ-027 Two latency=1 ops, grant=0 -> count=2, busy=1; third issue ignored; grant for one cycle -> count=1, busy=0.
REQ-028 Op in EXEC with specbit=1, spectag=4'b0010; prmiss with specfixtag=4'b0010 -> state IDLE, nothing pushed, cdb_req stays 0.
REQ-029 Queue {A spec tag 0001, B spec tag 0010}; prmiss specfixtag=0001 with grant=1 -> A dropped, B at head, count=1.
REQ-030 Queued entry spectag=0100, prsuccess prtag=0100 -> specbit=0; later prmiss specfixtag=0100 leaves entry intact.
REQ-031 With CUSTOM_ZERO_LAT_EN, latency=0 issue pr_result=32'hDEADBEEF -> cdb_req=1, cdb_result=32'hDEADBEEF after the issue edge; without it, one edge later.
